// File: rtl/j0_tag_receiver_pkg.sv
// Shared definitions for the J0 tag receiver: field widths, J0 line polarity,
// the tag record and a small helper for event-tag continuity.
package j0_tag_receiver_pkg;

  localparam int unsigned STAG_W    = 2;
  localparam int unsigned ETAG_W    = 3;
  localparam int unsigned TAG_W     = STAG_W + ETAG_W;
  localparam int unsigned EVT_CNT_W = 16;

  // J0 BUSY/WARN are open-collector style: pulling low asserts the condition.
  localparam logic J0_ASSERTED = 1'b0;
  localparam logic J0_RELEASED = 1'b1;

  typedef struct packed {
    logic [STAG_W-1:0] stag;
    logic [ETAG_W-1:0] etag;
  } tag_t;

  // Expected successor of an event tag (wraps modulo 2**ETAG_W).
  function automatic logic [ETAG_W-1:0] etag_next(input logic [ETAG_W-1:0] etag);
    return etag + {{(ETAG_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/j0_tag_receiver_if.sv
// J0 backplane signals between the GPIO-RM (master) and a front-end receiver (slave).
//   trig   : trigger, asynchronous to the receiver clock
//   stag   : spill tag
//   etag   : event tag
//   busy_n : active-low busy returned to the GPIO-RM
//   warn_n : active-low warning returned to the GPIO-RM
interface j0_tag_receiver_if;
  import j0_tag_receiver_pkg::*;

  logic              trig;
  logic [STAG_W-1:0] stag;
  logic [ETAG_W-1:0] etag;
  logic              busy_n;
  logic              warn_n;

  modport master (output trig, stag, etag, input busy_n, warn_n);
  modport slave  (input trig, stag, etag, output busy_n, warn_n);
endinterface

// File: rtl/j0_tag_receiver_tag_fifo.sv
// Synchronous FIFO with registered head data and valid flag.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i : write request and data (accepted when not full, or full with a pop)
//   pop_i        : pop request (ignored while empty)
//   rdata_o      : head entry, zero when empty
//   valid_o      : FIFO not empty
//   count_o      : current occupancy
module j0_tag_receiver_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             full, do_pop, do_push;

  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    // The incoming word becomes the head when it lands in the slot being read next.
    if (!valid_d) begin
      rdata_d = '0;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      rdata_d = wdata_i;
    end else begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/j0_tag_receiver.sv
// J0 front-end tag receiver. Synchronises the J0 trigger into the system clock,
// captures the spill/event tags into a FIFO, checks event-tag continuity and
// drives the active-low BUSY/WARN lines back onto J0.
//   sysclk_i/rst_ni : system clock, asynchronous active-low reset
//   j0             : J0 bus (trigger and tags in, busy_n/warn_n out)
//   local_busy_i   : busy from the local digitiser
//   tag_rd_i       : pop strobe for the tag FIFO
//   tag_dout_o     : {stag, etag} at FIFO head, tag_valid_o : FIFO not empty
//   trig_pulse_o   : one-cycle strobe per accepted trigger
//   evt_cnt_o      : accepted triggers since reset/clear
//   err_clr_i      : clears sticky flags, counter and continuity history
//   ovf_flag_o     : sticky, trigger dropped on a full FIFO
//   tag_err_o      : sticky, event-tag discontinuity inside a spill
module j0_tag_receiver
  import j0_tag_receiver_pkg::*;
#(
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned BusyMargin = 1
) (
  input  logic                 sysclk_i,
  input  logic                 rst_ni,
  j0_tag_receiver_if.slave     j0,
  input  logic                 local_busy_i,
  input  logic                 tag_rd_i,
  output logic [TAG_W-1:0]     tag_dout_o,
  output logic                 tag_valid_o,
  output logic                 trig_pulse_o,
  output logic [EVT_CNT_W-1:0] evt_cnt_o,
  input  logic                 err_clr_i,
  output logic                 ovf_flag_o,
  output logic                 tag_err_o
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  // Three-stage synchroniser (extra stage for metastability margin) plus history.
  logic [2:0] trig_sync_q;
  logic       trig_hist_q;
  logic       detect;

  // Tag pipeline matches the synchroniser depth so the captured tag lines up with detect.
  tag_t tag_p0_q, tag_p1_q, tag_p2_q;

  logic [CntW-1:0]      fifo_count;
  logic                 fifo_valid;
  logic                 accept, mismatch;
  logic [31:0]          free_slots;
  logic                 busy_cond;

  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 tag_err_q, tag_err_d;
  logic                 seen_q, seen_d;
  tag_t                 last_q, last_d;
  logic                 trig_pulse_q;
  logic                 busy_n_q, busy_n_d;
  logic                 warn_n_q, warn_n_d;

  assign detect = trig_sync_q[2] & ~trig_hist_q;

  // A full FIFO still accepts when a pop frees a slot in the same cycle.
  assign accept = detect && ((fifo_count != CntW'(FifoDepth)) || (tag_rd_i && fifo_valid));

  assign mismatch = seen_q && (tag_p2_q.stag == last_q.stag) &&
                    (tag_p2_q.etag != etag_next(last_q.etag));

  assign free_slots = 32'(FifoDepth) - 32'(fifo_count);
  assign busy_cond  = local_busy_i || (free_slots <= 32'(BusyMargin)) || ovf_q;

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (err_clr_i) evt_cnt_d = '0;
    if (accept)    evt_cnt_d = evt_cnt_d + EVT_CNT_W'(1);

    // Clear wins over a coincident detect for flags and history validity.
    ovf_d     = err_clr_i ? 1'b0 : (ovf_q | (detect & ~accept));
    tag_err_d = err_clr_i ? 1'b0 : (tag_err_q | (detect & mismatch));
    seen_d    = err_clr_i ? 1'b0 : (seen_q | detect);
    last_d    = detect ? tag_p2_q : last_q;

    busy_n_d  = busy_cond ? J0_ASSERTED : J0_RELEASED;
    warn_n_d  = (tag_err_q || ovf_q) ? J0_ASSERTED : J0_RELEASED;
  end

  always_ff @(posedge sysclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_sync_q  <= '0;
      trig_hist_q  <= 1'b0;
      tag_p0_q     <= '0;
      tag_p1_q     <= '0;
      tag_p2_q     <= '0;
      evt_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      tag_err_q    <= 1'b0;
      seen_q       <= 1'b0;
      last_q       <= '0;
      trig_pulse_q <= 1'b0;
      busy_n_q     <= J0_RELEASED;
      warn_n_q     <= J0_RELEASED;
    end else begin
      trig_sync_q  <= {trig_sync_q[1:0], j0.trig};
      trig_hist_q  <= trig_sync_q[2];
      tag_p0_q     <= '{stag: j0.stag, etag: j0.etag};
      tag_p1_q     <= tag_p0_q;
      tag_p2_q     <= tag_p1_q;
      evt_cnt_q    <= evt_cnt_d;
      ovf_q        <= ovf_d;
      tag_err_q    <= tag_err_d;
      seen_q       <= seen_d;
      last_q       <= last_d;
      trig_pulse_q <= accept;
      busy_n_q     <= busy_n_d;
      warn_n_q     <= warn_n_d;
    end
  end

  j0_tag_receiver_tag_fifo #(
    .Depth (FifoDepth),
    .Width (TAG_W)
  ) u_tag_fifo (
    .clk_i   (sysclk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .wdata_i (tag_p2_q),
    .pop_i   (tag_rd_i),
    .rdata_o (tag_dout_o),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign tag_valid_o  = fifo_valid;
  assign trig_pulse_o = trig_pulse_q;
  assign evt_cnt_o    = evt_cnt_q;
  assign ovf_flag_o   = ovf_q;
  assign tag_err_o    = tag_err_q;
  assign j0.busy_n    = busy_n_q;
  assign j0.warn_n    = warn_n_q;

endmodule

// File: doc/j0_tag_receiver.md
# j0_tag_receiver

Front-end side of the J0 backplane bus. It receives the trigger, spill tag and event tag that the GPIO-RM drives onto J0, and synchronises them into SYSCLK. Tags go into a small FIFO for local readout, and the block checks event-tag continuity. It drives the open-collector-style active-low BUSY and WARN lines back to the GPIO-RM, which ORs busy into the MTM busy.

## Interface
Parameters:
- FIFO_DEPTH, 4: tag FIFO entries (power of 2, 2..16)
- BUSY_MARGIN, 1: busy asserts when free entries ≤ BUSY_MARGIN

Ports:
- SYSCLK  in  1  32 MHz clock, same source as CLK_J0
- RST_N  in  1  asynchronous, active-low reset
- TRIG_J0  in  1  J0 trigger (async, rising edge = event)
- STAG_J0  in  2  spill tag
- ETAG_J0  in  3  event tag
- BUSY_J0  out  1  active-low busy to J0 (0 = busy)
- WARN_J0  out  1  active-low warning to J0 (0 = error flag set)
- LOCAL_BUSY  in  1  active-high busy from local digitiser
- TAG_RD  in  1  pop one FIFO entry (one-cycle strobe)
- TAG_DOUT  out  5  {stag, etag} at FIFO head
- TAG_VALID  out  1  FIFO not empty
- TRIG_PULSE  out  1  one-cycle accepted-trigger strobe
- EVT_CNT  out  16  accepted triggers since reset/clear
- ERR_CLR  in  1  clears sticky flags and EVT_CNT
- OVF_FLAG  out  1  sticky: trigger arrived while FIFO full
- TAG_ERR  out  1  sticky: event-tag discontinuity

## Operation
- TRIG_J0 passes through the existing async_input_sync synchroniser, then a 1-bit history register; rising edge = detect.
- STAG_J0/ETAG_J0 are delayed through 3 plain registers so they align with the detect cycle. They are captured on detect.
- On detect with FIFO not full:
  - push {stag, etag}
  - pulse TRIG_PULSE
  - EVT_CNT += 1 (wraps 0xFFFF→0)
- On detect with FIFO full:
  - entry dropped, no TRIG_PULSE, EVT_CNT unchanged
  - OVF_FLAG ← 1
- Continuity check: the block holds last_stag/last_etag and a valid bit `seen`.
  - If seen and stag == last_stag and etag != (last_etag+1) mod 8, then TAG_ERR ← 1.
  - If stag changed or seen == 0, no check.
  - Last values and `seen` update on every detect, including dropped ones.
- Busy: BUSY_J0 = ~(LOCAL_BUSY | (free ≤ BUSY_MARGIN) | OVF_FLAG). It is registered.
- WARN_J0 = ~(TAG_ERR | OVF_FLAG). It is registered.
- TAG_RD pops when TAG_VALID; TAG_RD while empty is ignored.
- Simultaneous push and pop:
  - when full: both occur, count unchanged, no overflow
  - when empty: push only
- ERR_CLR clears OVF_FLAG, TAG_ERR, EVT_CNT and `seen`; it does not flush the FIFO.
  - ERR_CLR coincident with detect: clear takes priority for flags; the event still pushes; EVT_CNT = 1 after that cycle.
- Reset values:
  - BUSY_J0=1, WARN_J0=1
  - TAG_VALID=0, TAG_DOUT=0, TRIG_PULSE=0, EVT_CNT=0
  - OVF_FLAG=0, TAG_ERR=0
  - FIFO empty, seen=0, synchroniser history=0
- Reset mid-event: any partially synchronised trigger is lost; no pulse after release.

## Timing
- Detect occurs on the 4th SYSCLK rising edge after TRIG_J0 rises, +1 cycle for metastability resolution.
  - TRIG_PULSE, push and EVT_CNT update are visible the cycle after detect.
- TRIG_J0 high ≥ 2 cycles and low ≥ 2 cycles between triggers. One edge gives at most one detect.
- Tags must be stable from 2 cycles before to 3 cycles after the TRIG_J0 rising edge.
- TAG_DOUT/TAG_VALID are registered. They reflect a push or pop 1 cycle after it happens.
- BUSY_J0 and WARN_J0 follow their causes with 1 cycle latency.
- Maximum sustained rate is one trigger per 4 cycles; back-to-back detects must all be accepted.

## Structure
- Shared include j0_defs.vh:
  - STAG_W=2, ETAG_W=3, TAG_W=5, EVT_CNT_W=16
  - J0 active-low polarity constants
- Sub-module tag_fifo: synchronous FIFO, registered outputs, count output, async active-low reset.
- Reuse the existing async_input_sync for TRIG_J0. Tag paths use plain registers.

## Test plan
- Reset, then 3 triggers with stag=1, etag=2,3,4:
  - 3 TRIG_PULSEs; EVT_CNT=3
  - TAG_DOUT pops 0x0A, 0x0B, 0x0C
  - TAG_ERR=0, WARN_J0=1
- FIFO_DEPTH=4, BUSY_MARGIN=1, no reads:
  - BUSY_J0 goes 0 after the 3rd push
  - 5th trigger dropped; OVF_FLAG=1, WARN_J0=0, EVT_CNT=4
- etag sequence 5,7 in the same spill: TAG_ERR=1.
  - Then stag changes with etag=0: no further error.
  - ERR_CLR: TAG_ERR=0, WARN_J0=1 one cycle later, EVT_CNT=0.
- FIFO full: TAG_RD coincident with detect gives count unchanged, OVF_FLAG=0, new tag at tail.
- TAG_RD with FIFO empty: no change. LOCAL_BUSY=1 gives BUSY_J0=0 after 1 cycle.
- Assert RST_N=0 two cycles after a TRIG_J0 rising edge:
  - no TRIG_PULSE after release
  - all outputs at reset values
